// File: rtl/parking_gate_arbiter.sv
// Barrier-gate arbiter shared by the entry and exit lanes of a parking lot.
// Round-robin lane arbitration, lowest-free-slot allocation, timed gate/full windows.
module parking_gate_arbiter #(
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned OPEN_CYCLES = 30,
    parameter int unsigned FULL_CYCLES = 30,
    localparam int unsigned SW = $clog2(SLOTS),
    localparam int unsigned CW = $clog2(SLOTS + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             entry_req_i,
    input  logic             exit_req_i,
    input  logic [SW-1:0]    exit_slot_i,
    output logic             entry_ack_o,
    output logic             entry_nack_o,
    output logic             exit_ack_o,
    output logic             err_exit_o,
    output logic [SW-1:0]    grant_slot_o,
    output logic             gate_open_o,
    output logic             full_flag_o,
    output logic [SLOTS-1:0] occupancy_o,
    output logic [CW-1:0]    free_count_o,
    output logic             busy_o
);

    localparam int unsigned MAXW = (OPEN_CYCLES > FULL_CYCLES) ? OPEN_CYCLES : FULL_CYCLES;
    localparam int unsigned TW   = $clog2(MAXW + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_REJECT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [SLOTS-1:0] occ_q, occ_d;
    logic [CW-1:0]    free_q, free_d;
    logic [SW-1:0]    grant_q, grant_d;
    logic             last_exit_q, last_exit_d;
    logic             entry_ack_q, entry_ack_d;
    logic             entry_nack_q, entry_nack_d;
    logic             exit_ack_q, exit_ack_d;
    logic             err_exit_q, err_exit_d;
    logic             gate_q, gate_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;

    logic             entry_v_s, exit_v_s;
    logic             entry_wins_s, exit_wins_s;
    logic             lot_full_s;

    function automatic logic [SW-1:0] lowest_free(input logic [SLOTS-1:0] occ);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                idx = SW'(i);
            end
        end
        return idx;
    endfunction

    // A request still held during its own ack cycle is the one just served, not a new one.
    assign entry_v_s    = entry_req_i & ~entry_ack_q & ~entry_nack_q;
    assign exit_v_s     = exit_req_i & ~exit_ack_q;
    assign lot_full_s   = (free_q == CW'(0));
    assign entry_wins_s = entry_v_s & (~exit_v_s | (~lot_full_s & last_exit_q));
    assign exit_wins_s  = exit_v_s & ~entry_wins_s;

    // Next-state, occupancy bookkeeping and registered-output decode.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        occ_d        = occ_q;
        free_d       = free_q;
        grant_d      = grant_q;
        last_exit_d  = last_exit_q;
        entry_ack_d  = 1'b0;
        entry_nack_d = 1'b0;
        exit_ack_d   = 1'b0;
        err_exit_d   = 1'b0;
        gate_d       = 1'b0;
        full_d       = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (entry_wins_s) begin
                    last_exit_d = 1'b0;
                    if (!lot_full_s) begin
                        grant_d                     = lowest_free(occ_q);
                        occ_d[lowest_free(occ_q)]   = 1'b1;
                        free_d                      = free_q - CW'(1);
                        entry_ack_d                 = 1'b1;
                        gate_d                      = 1'b1;
                        timer_d                     = TW'(OPEN_CYCLES - 1);
                        state_d                     = ST_OPEN;
                    end else begin
                        entry_nack_d = 1'b1;
                        full_d       = 1'b1;
                        timer_d      = TW'(FULL_CYCLES - 1);
                        state_d      = ST_REJECT;
                    end
                end else if (exit_wins_s) begin
                    last_exit_d = 1'b1;
                    exit_ack_d  = 1'b1;
                    if (occ_q[exit_slot_i]) begin
                        occ_d[exit_slot_i] = 1'b0;
                        grant_d            = exit_slot_i;
                        free_d             = free_q + CW'(1);
                        gate_d             = 1'b1;
                        timer_d            = TW'(OPEN_CYCLES - 1);
                        state_d            = ST_OPEN;
                    end else begin
                        err_exit_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (timer_q == TW'(0)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                    gate_d  = 1'b1;
                end
            end
            ST_REJECT: begin
                if (timer_q == TW'(0)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                    full_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = TW'(0);
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= TW'(0);
            occ_q        <= '0;
            free_q       <= CW'(SLOTS);
            grant_q      <= '0;
            last_exit_q  <= 1'b1;
            entry_ack_q  <= 1'b0;
            entry_nack_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            err_exit_q   <= 1'b0;
            gate_q       <= 1'b0;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            occ_q        <= occ_d;
            free_q       <= free_d;
            grant_q      <= grant_d;
            last_exit_q  <= last_exit_d;
            entry_ack_q  <= entry_ack_d;
            entry_nack_q <= entry_nack_d;
            exit_ack_q   <= exit_ack_d;
            err_exit_q   <= err_exit_d;
            gate_q       <= gate_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
        end
    end

    assign entry_ack_o  = entry_ack_q;
    assign entry_nack_o = entry_nack_q;
    assign exit_ack_o   = exit_ack_q;
    assign err_exit_o   = err_exit_q;
    assign grant_slot_o = grant_q;
    assign gate_open_o  = gate_q;
    assign full_flag_o  = full_q;
    assign occupancy_o  = occ_q;
    assign free_count_o = free_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: 4 slots, 30-cycle gate and full windows.
module tb_parking_gate_arbiter;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_slot;
    logic       entry_ack;
    logic       entry_nack;
    logic       exit_ack;
    logic       err_exit;
    logic [1:0] grant_slot;
    logic       gate_open;
    logic       full_flag;
    logic [3:0] occupancy;
    logic [2:0] free_count;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    parking_gate_arbiter #(
        .SLOTS      (4),
        .OPEN_CYCLES(30),
        .FULL_CYCLES(30)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .entry_req_i (entry_req),
        .exit_req_i  (exit_req),
        .exit_slot_i (exit_slot),
        .entry_ack_o (entry_ack),
        .entry_nack_o(entry_nack),
        .exit_ack_o  (exit_ack),
        .err_exit_o  (err_exit),
        .grant_slot_o(grant_slot),
        .gate_open_o (gate_open),
        .full_flag_o (full_flag),
        .occupancy_o (occupancy),
        .free_count_o(free_count),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called in the first cycle of a window; leaves the bench in the first IDLE cycle after it.
    task automatic wait_window(input string tag, input bit use_full);
        int w;
        w = 1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if ((use_full ? full_flag : gate_open) === 1'b1) w++;
            else break;
        end
        chk(tag, w, 30);
    endtask

    task automatic do_entry(input string tag, input logic [1:0] exp_slot, input logic [3:0] exp_occ);
        entry_req = 1'b1;
        tick();
        chk({tag, "_ack"}, entry_ack, 1'b1);
        chk({tag, "_slot"}, grant_slot, exp_slot);
        chk({tag, "_occ"}, occupancy, exp_occ);
        chk({tag, "_gate"}, gate_open, 1'b1);
        entry_req = 1'b0;
        wait_window({tag, "_width"}, 1'b0);
    endtask

    task automatic do_exit(input string tag, input logic [1:0] slot, input logic [3:0] exp_occ);
        exit_req  = 1'b1;
        exit_slot = slot;
        tick();
        chk({tag, "_ack"}, exit_ack, 1'b1);
        chk({tag, "_err"}, err_exit, 1'b0);
        chk({tag, "_slot"}, grant_slot, slot);
        chk({tag, "_occ"}, occupancy, exp_occ);
        exit_req = 1'b0;
        wait_window({tag, "_width"}, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = 2'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_occ", occupancy, 4'b0000);
        chk("rst_free", free_count, 3'd4);
        chk("rst_gate", gate_open, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {entry_ack, entry_nack, exit_ack, err_exit, full_flag}, 5'b0);
        tick();

        // Fill the lot from slot 0 upward.
        do_entry("fill0", 2'd0, 4'b0001);
        do_entry("fill1", 2'd1, 4'b0011);
        do_entry("fill2", 2'd2, 4'b0111);
        do_entry("fill3", 2'd3, 4'b1111);
        chk("full_free", free_count, 3'd0);

        // Entry with lot full is rejected.
        entry_req = 1'b1;
        tick();
        chk("rej_nack", entry_nack, 1'b1);
        chk("rej_noack", entry_ack, 1'b0);
        chk("rej_flag", full_flag, 1'b1);
        chk("rej_gate", gate_open, 1'b0);
        chk("rej_occ", occupancy, 4'b1111);
        entry_req = 1'b0;
        wait_window("rej_width", 1'b1);
        chk("rej_idle", busy, 1'b0);

        // Release slot 1, then re-allocate it.
        do_exit("ex1", 2'd1, 4'b1101);
        chk("ex1_free", free_count, 3'd1);
        do_entry("re1", 2'd1, 4'b1111);

        // Drain to 4'b0001 (last served becomes exit).
        do_exit("dr1", 2'd1, 4'b1101);
        do_exit("dr2", 2'd2, 4'b1001);
        do_exit("dr3", 2'd3, 4'b0001);

        // Simultaneous requests: entry first, then exit beats a re-raised entry.
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd0;
        tick();
        chk("pair_eack", entry_ack, 1'b1);
        chk("pair_noxack", exit_ack, 1'b0);
        chk("pair_slot", grant_slot, 2'd1);
        chk("pair_occ", occupancy, 4'b0011);
        entry_req = 1'b0;
        wait_window("pair_w1", 1'b0);
        entry_req = 1'b1;
        tick();
        chk("pair2_xack", exit_ack, 1'b1);
        chk("pair2_noeack", entry_ack, 1'b0);
        chk("pair2_slot", grant_slot, 2'd0);
        chk("pair2_occ", occupancy, 4'b0010);
        chk("pair2_free", free_count, 3'd3);
        exit_req = 1'b0;
        wait_window("pair2_w", 1'b0);
        tick();
        chk("pair3_eack", entry_ack, 1'b1);
        chk("pair3_slot", grant_slot, 2'd0);
        chk("pair3_occ", occupancy, 4'b0011);
        entry_req = 1'b0;
        wait_window("pair3_w", 1'b0);

        // Full lot, both requests: exit wins, entry then gets the freed slot.
        do_entry("f2", 2'd2, 4'b0111);
        do_entry("f3", 2'd3, 4'b1111);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd2;
        tick();
        chk("fx_xack", exit_ack, 1'b1);
        chk("fx_nonack", entry_nack, 1'b0);
        chk("fx_occ", occupancy, 4'b1011);
        exit_req = 1'b0;
        wait_window("fx_w", 1'b0);
        tick();
        chk("fx_eack", entry_ack, 1'b1);
        chk("fx_nonack2", entry_nack, 1'b0);
        chk("fx_eslot", grant_slot, 2'd2);
        entry_req = 1'b0;
        wait_window("fx_w2", 1'b0);

        // Exit of an empty slot: error pulse, no gate, request held through the ack cycle.
        do_exit("ee_pre", 2'd2, 4'b1011);
        exit_req  = 1'b1;
        exit_slot = 2'd2;
        tick();
        chk("ee_ack", exit_ack, 1'b1);
        chk("ee_err", err_exit, 1'b1);
        chk("ee_gate", gate_open, 1'b0);
        chk("ee_busy", busy, 1'b0);
        chk("ee_occ", occupancy, 4'b1011);
        chk("ee_free", free_count, 3'd1);
        tick();
        exit_req = 1'b0;
        chk("ee_once", {exit_ack, err_exit}, 2'b00);
        tick();

        // Reset ten cycles into an OPEN window.
        entry_req = 1'b1;
        tick();
        chk("mr_ack", entry_ack, 1'b1);
        chk("mr_slot", grant_slot, 2'd2);
        entry_req = 1'b0;
        repeat (9) tick();
        chk("mr_gate_pre", gate_open, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_gate", gate_open, 1'b0);
        chk("mr_occ", occupancy, 4'b0000);
        chk("mr_free", free_count, 3'd4);
        chk("mr_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
